fetch_aligner: RTL

Instruction fetch aligner between the instruction memory port and the instruction decoder. It consumes word-aligned 32-bit memory words and produces one instruction per handshake with its PC: either a full 32-bit instruction or a 16-bit compressed instruction, zero-extended. It handles 32-bit instructions that straddle a word boundary and branch redirects to halfword-aligned targets. Its output feeds the decoder's 32-bit opcode input directly.

---
 rtl/fetch_aligner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_aligner.sv
// Fetch aligner: turns word-aligned 32-bit memory words into a stream of 16/32-bit
// instructions with their PCs, handling boundary-straddling instructions and redirects.
//
// Handshakes: the memory side offers i_fetch_data while i_fetch_valid is high and the
// word is consumed in any cycle where o_fetch_ack is high; the decoder side takes
// o_instr/o_pc/o_compressed on a rising edge where o_valid && i_ready, and while
// o_valid && !i_ready those outputs stay unchanged.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_fetch_addr,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_data,
  output logic        o_fetch_ack,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_compressed,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SKIP  = 2'd1,
    ST_HALF  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_ADDR  = {RESET_PC[31:2], 2'b00};
  localparam state_e      RESET_STATE = RESET_PC[1] ? ST_SKIP : ST_EMPTY;

  state_e      state_q, state_d;
  logic [15:0] hw_buf_q, hw_buf_d;
  logic [31:0] hw_pc_q, hw_pc_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        comp_q, comp_d;

  logic        load;
  logic        ack;
  logic        buf_full;
  logic        data_full;
  logic        unused_rpc_bit0;

  assign unused_rpc_bit0 = i_redirect_pc[0];

  assign load      = !valid_q || i_ready;
  assign buf_full  = (hw_buf_q[1:0] == 2'b11);
  assign data_full = (i_fetch_data[1:0] == 2'b11);

  always_comb begin
    state_d  = state_q;
    hw_buf_d = hw_buf_q;
    hw_pc_d  = hw_pc_q;
    addr_d   = addr_q;
    valid_d  = load ? 1'b0 : valid_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    comp_d   = comp_q;
    ack      = 1'b0;

    if (i_redirect) begin
      // Flush: any pending output is dropped even if the decoder is ready.
      valid_d = 1'b0;
      addr_d  = {i_redirect_pc[31:2], 2'b00};
      state_d = i_redirect_pc[1] ? ST_SKIP : ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (i_fetch_valid && load) begin
            ack     = 1'b1;
            valid_d = 1'b1;
            pc_d    = addr_q;
            if (data_full) begin
              instr_d = i_fetch_data;
              comp_d  = 1'b0;
            end else begin
              instr_d  = {16'h0000, i_fetch_data[15:0]};
              comp_d   = 1'b1;
              hw_buf_d = i_fetch_data[31:16];
              hw_pc_d  = addr_q + 32'd2;
              state_d  = ST_HALF;
            end
          end
        end
        ST_SKIP: begin
          // The low half precedes the branch target and is never emitted.
          if (i_fetch_valid) begin
            ack      = 1'b1;
            hw_buf_d = i_fetch_data[31:16];
            hw_pc_d  = addr_q + 32'd2;
            state_d  = ST_HALF;
          end
        end
        ST_HALF: begin
          if (!buf_full) begin
            if (load) begin
              valid_d = 1'b1;
              instr_d = {16'h0000, hw_buf_q};
              pc_d    = hw_pc_q;
              comp_d  = 1'b1;
              state_d = ST_EMPTY;
            end
          end else if (i_fetch_valid && load) begin
            ack      = 1'b1;
            valid_d  = 1'b1;
            instr_d  = {i_fetch_data[15:0], hw_buf_q};
            pc_d     = hw_pc_q;
            comp_d   = 1'b0;
            hw_buf_d = i_fetch_data[31:16];
            hw_pc_d  = addr_q + 32'd2;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase

      if (ack) begin
        addr_d = addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= RESET_STATE;
      hw_buf_q <= 16'h0000;
      hw_pc_q  <= 32'h0000_0000;
      addr_q   <= RESET_ADDR;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      pc_q     <= 32'h0000_0000;
      comp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hw_buf_q <= hw_buf_d;
      hw_pc_q  <= hw_pc_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      comp_q   <= comp_d;
    end
  end

  // Memory must not see a consume while the block is being reset.
  assign o_fetch_ack  = ack && !i_rst;
  assign o_fetch_addr = addr_q;
  assign o_valid      = valid_q;
  assign o_instr      = instr_q;
  assign o_pc         = pc_q;
  assign o_compressed = comp_q;
  assign o_dbg_state  = state_q;

endmodule
